// File: rtl/flex_counter_ud_if.sv
`default_nettype none
//==============================================================================
// Module      : flex_counter_ud_if
// Description : Control/status bundle for the up/down flexible counter.
// Revision    : 1.0 - initial release
//==============================================================================
interface flex_counter_ud_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    clr;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    count_enable;
    logic                    count_up;
    logic                    saturate;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;
    logic                    bottom_flag;
    logic                    wrap_pulse;

    modport master (
        output clr, load, load_val, count_enable, count_up, saturate, rollover_val,
        input  count_out, rollover_flag, bottom_flag, wrap_pulse
    );

    modport slave (
        input  clr, load, load_val, count_enable, count_up, saturate, rollover_val,
        output count_out, rollover_flag, bottom_flag, wrap_pulse
    );
endinterface
`default_nettype wire

// File: rtl/flex_counter_ud.sv
`default_nettype none
//==============================================================================
// Module      : flex_counter_ud
// Description : Up/down counter over the range 1..rollover_val with wrap or
//               saturate boundaries, load/clear and registered status flags.
// Revision    : 1.0 - initial release
//==============================================================================
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4
) (
    input  wire logic         clk,
    input  wire logic         n_rst,
    flex_counter_ud_if.slave  bus
);
    localparam logic [NUM_CNT_BITS-1:0] c_zero = '0;
    localparam logic [NUM_CNT_BITS-1:0] c_one  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_rollover;
    logic                    r_bottom;
    logic                    r_wrap;

    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    w_wrap;
    logic                    w_rv_valid;

    assign w_rv_valid = (bus.rollover_val != c_zero);

    // All boundary tests compare at full width, so rollover_val = all-ones
    // needs no special handling.
    always_comb begin
        w_next = r_count;
        w_wrap = 1'b0;
        if (bus.clr) begin
            w_next = c_zero;
        end else if (bus.load) begin
            w_next = bus.load_val;
        end else if (bus.count_enable && w_rv_valid) begin
            if (bus.count_up) begin
                if (r_count < bus.rollover_val) begin
                    w_next = r_count + c_one;
                end else if (bus.saturate) begin
                    w_next = bus.rollover_val;
                end else begin
                    w_next = c_one;
                    w_wrap = 1'b1;
                end
            end else begin
                if (r_count > bus.rollover_val) begin
                    w_next = bus.rollover_val;
                end else if (r_count > c_one) begin
                    w_next = r_count - c_one;
                end else if (bus.saturate) begin
                    w_next = c_one;
                end else begin
                    w_next = bus.rollover_val;
                    w_wrap = 1'b1;
                end
            end
        end
    end

    // Flags are computed from the next count so they line up with count_out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count    <= c_zero;
            r_rollover <= 1'b0;
            r_bottom   <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_rollover <= w_rv_valid && (w_next == bus.rollover_val);
            r_bottom   <= w_rv_valid && (w_next == c_one);
            r_wrap     <= w_wrap;
        end
    end

    assign bus.count_out     = r_count;
    assign bus.rollover_flag = r_rollover;
    assign bus.bottom_flag   = r_bottom;
    assign bus.wrap_pulse    = r_wrap;
endmodule
`default_nettype wire

// File: tb/tb_flex_counter_ud.sv
`default_nettype none
//==============================================================================
// Module      : tb_flex_counter_ud
// Description : Directed vector bench for flex_counter_ud (N=4 and N=8).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_flex_counter_ud;
    logic clk;
    logic n_rst;

    flex_counter_ud_if #(.NUM_CNT_BITS(4)) if4 ();
    flex_counter_ud_if #(.NUM_CNT_BITS(8)) if8 ();

    flex_counter_ud #(.NUM_CNT_BITS(4)) dut4 (.clk(clk), .n_rst(n_rst), .bus(if4.slave));
    flex_counter_ud #(.NUM_CNT_BITS(8)) dut8 (.clk(clk), .n_rst(n_rst), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       clr;
        logic       load;
        logic [3:0] load_val;
        logic       en;
        logic       up;
        logic       sat;
        logic [3:0] rv;
        logic [3:0] exp_cnt;
        logic       exp_roll;
        logic       exp_bot;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(string nm, logic c, logic l, logic [3:0] lv, logic e,
                                logic u, logic s, logic [3:0] r, logic [3:0] ec,
                                logic er, logic eb, logic ew);
        vec_t v;
        v.name = nm; v.clr = c; v.load = l; v.load_val = lv; v.en = e; v.up = u;
        v.sat = s; v.rv = r; v.exp_cnt = ec; v.exp_roll = er; v.exp_bot = eb;
        v.exp_wrap = ew;
        return v;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic drive4(logic c, logic l, logic [3:0] lv, logic e, logic u,
                          logic s, logic [3:0] r);
        if4.clr = c; if4.load = l; if4.load_val = lv; if4.count_enable = e;
        if4.count_up = u; if4.saturate = s; if4.rollover_val = r;
    endtask

    task automatic chk4(string nm, logic [3:0] c, logic r, logic b, logic w);
        chk({nm, ".count"}, int'(if4.count_out), int'(c));
        chk({nm, ".roll"},  int'(if4.rollover_flag), int'(r));
        chk({nm, ".bot"},   int'(if4.bottom_flag), int'(b));
        chk({nm, ".wrap"},  int'(if4.wrap_pulse), int'(w));
    endtask

    task automatic chk8(string nm, logic [7:0] c, logic r, logic b, logic w);
        chk({nm, ".count"}, int'(if8.count_out), int'(c));
        chk({nm, ".roll"},  int'(if8.rollover_flag), int'(r));
        chk({nm, ".bot"},   int'(if8.bottom_flag), int'(b));
        chk({nm, ".wrap"},  int'(if8.wrap_pulse), int'(w));
    endtask

    initial begin
        // name, clr, load, load_val, en, up, sat, rv -> cnt, roll, bot, wrap
        vecs.push_back(mk("up5_1",   0,0,0, 1,1,0, 5,  1, 0,1,0));
        vecs.push_back(mk("up5_2",   0,0,0, 1,1,0, 5,  2, 0,0,0));
        vecs.push_back(mk("up5_3",   0,0,0, 1,1,0, 5,  3, 0,0,0));
        vecs.push_back(mk("up5_4",   0,0,0, 1,1,0, 5,  4, 0,0,0));
        vecs.push_back(mk("up5_5",   0,0,0, 1,1,0, 5,  5, 1,0,0));
        vecs.push_back(mk("up5_w1",  0,0,0, 1,1,0, 5,  1, 0,1,1));
        vecs.push_back(mk("clr",     1,0,0, 0,1,0, 5,  0, 0,0,0));
        vecs.push_back(mk("dn3_3",   0,0,0, 1,0,0, 3,  3, 1,0,1));
        vecs.push_back(mk("dn3_2",   0,0,0, 1,0,0, 3,  2, 0,0,0));
        vecs.push_back(mk("dn3_1",   0,0,0, 1,0,0, 3,  1, 0,1,0));
        vecs.push_back(mk("dn3_w3",  0,0,0, 1,0,0, 3,  3, 1,0,1));
        vecs.push_back(mk("sat_ld3", 0,1,3, 0,1,1, 4,  3, 0,0,0));
        vecs.push_back(mk("sat_4a",  0,0,0, 1,1,1, 4,  4, 1,0,0));
        vecs.push_back(mk("sat_4b",  0,0,0, 1,1,1, 4,  4, 1,0,0));
        vecs.push_back(mk("sat_4c",  0,0,0, 1,1,1, 4,  4, 1,0,0));
        vecs.push_back(mk("pri_ld2", 0,1,2, 0,1,0, 6,  2, 0,0,0));
        vecs.push_back(mk("pri_clr", 1,1,9, 1,1,0, 6,  0, 0,0,0));
        vecs.push_back(mk("pri_ld9", 0,1,9, 1,0,0, 6,  9, 0,0,0));
        vecs.push_back(mk("pri_dn6", 0,0,0, 1,0,0, 6,  6, 1,0,0));
        vecs.push_back(mk("rv0_hold",0,0,0, 1,1,0, 0,  6, 0,0,0));
        vecs.push_back(mk("ld15",    0,1,15,0,1,0, 6, 15, 0,0,0));
        vecs.push_back(mk("above_up",0,0,0, 1,1,0, 6,  1, 0,1,1));
        vecs.push_back(mk("hold",    0,0,0, 0,1,0, 6,  1, 0,1,0));
        vecs.push_back(mk("satdn1",  0,0,0, 1,0,1, 6,  1, 0,1,0));
        vecs.push_back(mk("ld14",    0,1,14,0,1,0, 15,14, 0,0,0));
        vecs.push_back(mk("max_15",  0,0,0, 1,1,0, 15,15, 1,0,0));
        vecs.push_back(mk("max_w1",  0,0,0, 1,1,0, 15, 1, 0,1,1));
        vecs.push_back(mk("ld0",     0,1,0, 0,1,0, 15, 0, 0,0,0));

        n_rst = 1'b0;
        drive4(0,0,0,0,1,0,0);
        if8.clr = 0; if8.load = 0; if8.load_val = '0; if8.count_enable = 0;
        if8.count_up = 1; if8.saturate = 0; if8.rollover_val = '0;
        #12;
        chk4("reset", 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive4(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en,
                   vecs[i].up, vecs[i].sat, vecs[i].rv);
            @(posedge clk);
            #1;
            chk4(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_roll,
                 vecs[i].exp_bot, vecs[i].exp_wrap);
        end

        // Asynchronous reset between edges while flags are active.
        drive4(0,1,3,0,1,0,3);
        @(posedge clk);
        #1;
        chk4("pre_rst", 3, 1, 0, 0);
        drive4(0,0,0,1,1,0,5);
        #2;
        n_rst = 1'b0;
        #1;
        chk4("async_rst", 0, 0, 0, 0);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk4("post_rst", 1, 0, 1, 0);

        // Full-width rollover on the 8-bit instance.
        drive4(0,0,0,0,1,0,5);
        if8.load = 1; if8.load_val = 8'd254; if8.rollover_val = 8'd255;
        @(posedge clk);
        #1;
        chk8("w8_ld254", 254, 0, 0, 0);
        if8.load = 0; if8.count_enable = 1;
        @(posedge clk);
        #1;
        chk8("w8_255", 255, 1, 0, 0);
        @(posedge clk);
        #1;
        chk8("w8_w1", 1, 0, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
`default_nettype wire
